// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// lane arithmetic and the alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned f_lanes(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // A "word" access always means the full DATA_W, so any nonzero lane is misaligned.
  function automatic logic f_misaligned(input size_e sz, input logic [7:0] lane);
    case (sz)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 8'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane enables and write-data placement for stores; lane extraction and
// sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANES     = DATA_W / 8,
  parameter int LANE_BITS = 2
) (
  input  size_e                i_size,
  input  logic [LANE_BITS-1:0] i_lane,
  input  logic                 i_unsigned,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [DATA_W-1:0]    i_rword,
  output logic [LANES-1:0]     o_be,
  output logic [DATA_W-1:0]    o_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [LANE_BITS+2:0] w_sh;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;

  assign w_sh = {i_lane, 3'b000};

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    w_byte  = i_rword[w_sh +: 8];
    w_half  = i_rword[w_sh +: 16];
    case (i_size)
      SZ_BYTE: begin
        o_be    = LANES'(1) << i_lane;
        o_wdata = DATA_W'(i_wdata[7:0]) << w_sh;
        o_rdata = i_unsigned ? DATA_W'(w_byte) : {{(DATA_W-8){w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = LANES'(2'b11) << i_lane;
        o_wdata = DATA_W'(i_wdata[15:0]) << w_sh;
        o_rdata = i_unsigned ? DATA_W'(w_half) : {{(DATA_W-16){w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_be    = '1;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable little-endian data memory with byte/half/word access,
// one-cycle registered loads, read-before-write, and error pulses for rejected accesses.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              Error
);

  localparam int unsigned LANES     = f_lanes(DATA_W);
  localparam int          LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Contents survive reset; only the power-up image seeds the first ten words.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{
    0: DATA_W'(0), 1: DATA_W'(1), 2: DATA_W'(2), 3: DATA_W'(3), 4: DATA_W'(4),
    5: DATA_W'(5), 6: DATA_W'(6), 7: DATA_W'(7), 8: DATA_W'(8), 9: DATA_W'(9),
    default: '0
  };

  logic [DATA_W-1:0]    r_rd_data;
  logic                 r_rd_vld;
  logic                 r_err;

  size_e                w_size;
  logic [ADDR_W-1:0]    w_word_idx;
  logic [IDX_W-1:0]     w_idx;
  logic [LANE_BITS-1:0] w_lane;
  logic                 w_bad;
  logic [DATA_W-1:0]    w_rword;
  logic [LANES-1:0]     w_be;
  logic [DATA_W-1:0]    w_wdata_al;
  logic [DATA_W-1:0]    w_load;

  assign w_size     = size_e'(Size);
  assign w_word_idx = Address / ADDR_W'(LANES);
  assign w_lane     = LANE_BITS'(Address % ADDR_W'(LANES));
  assign w_idx      = w_word_idx[IDX_W-1:0];
  assign w_rword    = r_mem[w_idx];
  assign w_bad      = (w_word_idx >= ADDR_W'(DEPTH))
                    | f_misaligned(w_size, 8'(w_lane))
                    | (w_size == SZ_RSVD);

  mem_lane_align #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .LANE_BITS(LANE_BITS)
  ) u_align (
    .i_size    (w_size),
    .i_lane    (w_lane),
    .i_unsigned(Unsigned),
    .i_wdata   (WriteData),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_al),
    .o_rdata   (w_load)
  );

  always_ff @(posedge Clk) begin
    if (Rst_n && MemWrite && !w_bad) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_be[l]) r_mem[w_idx][l*8 +: 8] <= w_wdata_al[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else if (MemRead) begin
      r_rd_data <= w_bad ? '0 : w_load;
      r_rd_vld  <= 1'b1;
      r_err     <= w_bad;
    end else begin
      r_rd_vld  <= 1'b0;
      r_err     <= MemWrite & w_bad;
    end
  end

  assign ReadData  = r_rd_data;
  assign ReadValid = r_rd_vld;
  assign Error     = r_err;

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits (multiple of 8, at least 32).
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning number of words in the array.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 The block SHALL have port Clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port Address  input  ADDR_W  byte address.
REQ-007 The block SHALL have port WriteData  input  DATA_W  store data, right-aligned.
REQ-008 The block SHALL have port MemWrite  input  1  store request.
REQ-009 The block SHALL have port MemRead  input  1  load request.
REQ-010 The block SHALL have port Size  input  2  access size: 00 byte, 01 half, 10 word; 11 reserved.
REQ-011 The block SHALL have port Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-012 The block SHALL have port ReadData  output  DATA_W  registered load result.
REQ-013 The block SHALL have port ReadValid  output  1  ReadData valid this cycle.
REQ-014 The block SHALL have port Error  output  1  one-cycle pulse for a rejected access.

Function
REQ-015 The word index SHALL be Address divided by DATA_W/8; the byte lane SHALL be the low address bits; lanes SHALL be little-endian.
REQ-016 A store SHALL update only the addressed byte lanes at the rising Clk edge where MemWrite=1; other lanes SHALL keep their values.
REQ-017 A load sampled with MemRead=1 at edge N SHALL drive ReadData and ReadValid=1 after edge N, for exactly one cycle (latency 1).
REQ-018 When no load is accepted, ReadValid SHALL be 0 and ReadData SHALL hold its last value.
REQ-019 Byte and half loads SHALL be extracted from the addressed lane and extended to DATA_W per Unsigned.
REQ-020 With MemRead=1 and MemWrite=1 at the same edge and the same word, the load SHALL return pre-store data (read-before-write).
REQ-021 A load issued at the edge after a store to the same word SHALL return the stored data.
REQ-022 A half access with Address[0]=1 SHALL be misaligned, and so SHALL a word access with any nonzero lane bits.
REQ-023 Misaligned, out-of-range (word index >= DEPTH) or Size=11 accesses SHALL suppress the store, and a rejected load SHALL return ReadData=0 with ReadValid=1.
REQ-024 In every case of REQ-023, Error SHALL be 1 for the one cycle aligned with the response.
REQ-025 MemRead=0 and MemWrite=0 SHALL leave all outputs except ReadData at 0 after the next edge.

Reset
REQ-026 Rst_n=0 SHALL immediately force ReadData=0, ReadValid=0 and Error=0, regardless of Clk.
REQ-027 Array contents SHALL NOT be cleared by reset; at time zero, word i SHALL be initialised to i for i=0..9 and to 0 otherwise.
REQ-028 Stores presented while Rst_n=0 SHALL be ignored.
REQ-029 A load accepted on the edge where Rst_n deasserts SHALL complete normally.

Structure
REQ-030 The Size encodings, the lane-count constant and the alignment-check function SHALL reside in a shared package mem_pkg.
REQ-031 Lane-enable generation and load extraction/extension SHALL be one sub-module, mem_lane_align, instantiated once.
REQ-032 The array SHALL be a single DEPTH x DATA_W register array with per-lane write enables and no asynchronous read path.

Verification
REQ-033 Reset, then load word from Address 0x10 -> next cycle ReadData=4, ReadValid=1, Error=0.
REQ-034 Store word 0x8000_00FF at 0x20, then load signed byte at 0x20 -> 0xFFFF_FFFF; unsigned byte at 0x23 -> 0x0000_0080.
REQ-035 Store half 0xABCD at 0x0E with prior word 3 -> word 3 reads 0xABCD_0003.
REQ-036 Simultaneous store of 0x55 and load at 0x24 -> load returns 9; the following load returns 0x55.
REQ-037 Word store at 0x22, then load at 4*DEPTH -> Error pulses each time, memory unchanged, ReadData=0.
REQ-038 Assert Rst_n=0 mid-cycle during a pending load -> ReadValid and ReadData drop to 0 immediately, before the next Clk edge.
